// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the memory arbiter: widths, IO window, size codes and FSM states.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam logic [31:0] IO_BASE    = 32'h0003_0000;

  localparam logic [2:0] SZ_BYTE = 3'd1;
  localparam logic [2:0] SZ_HALF = 3'd2;
  localparam logic [2:0] SZ_WORD = 3'd4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_FETCH,
    BUSY_LS
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of icache, load/store, rollback/IO and memory-engine signals around the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = mem_arbiter_pkg::ADDR_WIDTH
) ();

  logic                  in_rollback;
  logic                  in_icache_ena;
  logic [ADDR_WIDTH-1:0] in_icache_addr;
  logic                  out_icache_ok;
  logic [ADDR_WIDTH-1:0] out_icache_data;
  logic                  in_ls_ena;
  logic                  in_ls_iswrite;
  logic [ADDR_WIDTH-1:0] in_ls_addr;
  logic [2:0]            in_ls_size;
  logic [ADDR_WIDTH-1:0] in_ls_data;
  logic                  out_ls_ok;
  logic [ADDR_WIDTH-1:0] out_ls_data;
  logic                  in_io_buffer_full;
  logic                  out_mem_ena;
  logic                  out_mem_iswrite;
  logic [ADDR_WIDTH-1:0] out_mem_addr;
  logic [2:0]            out_mem_size;
  logic [ADDR_WIDTH-1:0] out_mem_data;
  logic                  in_mem_busy;
  logic                  in_mem_ok;
  logic [ADDR_WIDTH-1:0] in_mem_data;

  // Arbiter side.
  modport master (
    input  in_rollback, in_icache_ena, in_icache_addr, in_ls_ena, in_ls_iswrite, in_ls_addr,
           in_ls_size, in_ls_data, in_io_buffer_full, in_mem_busy, in_mem_ok, in_mem_data,
    output out_icache_ok, out_icache_data, out_ls_ok, out_ls_data, out_mem_ena, out_mem_iswrite,
           out_mem_addr, out_mem_size, out_mem_data
  );

  // Requester / memory-engine side.
  modport slave (
    output in_rollback, in_icache_ena, in_icache_addr, in_ls_ena, in_ls_iswrite, in_ls_addr,
           in_ls_size, in_ls_data, in_io_buffer_full, in_mem_busy, in_mem_ok, in_mem_data,
    input  out_icache_ok, out_icache_data, out_ls_ok, out_ls_data, out_mem_ena, out_mem_iswrite,
           out_mem_addr, out_mem_size, out_mem_data
  );

endinterface

// File: rtl/mem_arbiter_arb_priority_sel.sv
// Combinational grant selector: forced fetch when starved, else unstalled LS, else fetch.
module arb_priority_sel #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic             en,
  input  logic             icache_pend,
  input  logic             ls_pend,
  input  logic             ls_stall,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant_fetch,
  output logic             grant_ls
);

  logic starved;
  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    grant_fetch = 1'b0;
    grant_ls    = 1'b0;
    if (en) begin
      if (icache_pend && starved) begin
        grant_fetch = 1'b1;
      end else if (ls_pend && !ls_stall) begin
        grant_ls = 1'b1;
      end else if (icache_pend) begin
        grant_fetch = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-serial memory engine between icache fetch and the LS unit, one transaction
// at a time, with starvation limit, IO-store stall and rollback discard.
module mem_arbiter #(
  parameter int unsigned           ADDR_WIDTH   = mem_arbiter_pkg::ADDR_WIDTH,
  parameter int unsigned           STARVE_LIMIT = 4,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE      = ADDR_WIDTH'(mem_arbiter_pkg::IO_BASE)
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus
);
  import mem_arbiter_pkg::*;

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      starve_q;
  logic                  discard_q;
  logic                  mem_ena_q;
  logic                  mem_iswrite_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [2:0]            mem_size_q;
  logic [ADDR_WIDTH-1:0] mem_data_q;
  logic                  icache_ok_q, ls_ok_q;
  logic [ADDR_WIDTH-1:0] icache_data_q, ls_data_q;

  logic icache_pend, ls_pend, ls_stall, sel_en;
  logic grant_fetch, grant_ls;
  logic deliver_fetch, deliver_ls, set_discard;

  // A requester is masked while its ok pulse is out, so a still-held request is not reissued.
  assign icache_pend = bus.in_icache_ena & ~icache_ok_q;
  assign ls_pend     = bus.in_ls_ena & ~ls_ok_q;
  assign ls_stall    = bus.in_ls_iswrite & (bus.in_ls_addr >= IO_BASE) & bus.in_io_buffer_full;
  assign sel_en      = (state_q == IDLE) & ~bus.in_mem_busy & ~bus.in_rollback;

  arb_priority_sel #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_sel (
    .en         (sel_en),
    .icache_pend(icache_pend),
    .ls_pend    (ls_pend),
    .ls_stall   (ls_stall),
    .starve_cnt (starve_q),
    .grant_fetch(grant_fetch),
    .grant_ls   (grant_ls)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_fetch) begin
          state_d = BUSY_FETCH;
        end else if (grant_ls) begin
          state_d = BUSY_LS;
        end
      end
      BUSY_FETCH, BUSY_LS: begin
        if (bus.in_mem_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stores are never cancelled; fetches and loads are dropped on rollback, even same-cycle.
  always_comb begin
    deliver_fetch = 1'b0;
    deliver_ls    = 1'b0;
    set_discard   = 1'b0;
    unique case (state_q)
      BUSY_FETCH: begin
        deliver_fetch = bus.in_mem_ok & ~discard_q & ~bus.in_rollback;
        set_discard   = bus.in_rollback;
      end
      BUSY_LS: begin
        if (mem_iswrite_q) begin
          deliver_ls = bus.in_mem_ok;
        end else begin
          deliver_ls  = bus.in_mem_ok & ~discard_q & ~bus.in_rollback;
          set_discard = bus.in_rollback;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      discard_q     <= 1'b0;
      starve_q      <= '0;
      mem_ena_q     <= 1'b0;
      mem_iswrite_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_size_q    <= '0;
      mem_data_q    <= '0;
      icache_ok_q   <= 1'b0;
      icache_data_q <= '0;
      ls_ok_q       <= 1'b0;
      ls_data_q     <= '0;
    end else begin
      if (state_d == IDLE) begin
        discard_q <= 1'b0;
      end else if (set_discard) begin
        discard_q <= 1'b1;
      end

      if (!bus.in_icache_ena || grant_fetch) begin
        starve_q <= '0;
      end else if (grant_ls && (starve_q != CNT_W'(STARVE_LIMIT))) begin
        starve_q <= starve_q + 1'b1;
      end

      mem_ena_q <= grant_fetch | grant_ls;
      if (grant_fetch) begin
        mem_iswrite_q <= 1'b0;
        mem_addr_q    <= bus.in_icache_addr;
        mem_size_q    <= SZ_WORD;
        mem_data_q    <= '0;
      end else if (grant_ls) begin
        mem_iswrite_q <= bus.in_ls_iswrite;
        mem_addr_q    <= bus.in_ls_addr;
        mem_size_q    <= bus.in_ls_size;
        mem_data_q    <= bus.in_ls_data;
      end

      icache_ok_q <= deliver_fetch;
      if (deliver_fetch) icache_data_q <= bus.in_mem_data;
      ls_ok_q <= deliver_ls;
      if (deliver_ls) ls_data_q <= bus.in_mem_data;
    end
  end

  assign bus.out_mem_ena     = mem_ena_q;
  assign bus.out_mem_iswrite = mem_iswrite_q;
  assign bus.out_mem_addr    = mem_addr_q;
  assign bus.out_mem_size    = mem_size_q;
  assign bus.out_mem_data    = mem_data_q;
  assign bus.out_icache_ok   = icache_ok_q;
  assign bus.out_icache_data = icache_data_q;
  assign bus.out_ls_ok       = ls_ok_q;
  assign bus.out_ls_data     = ls_data_q;

endmodule
